rr_port_arbiter: RTL and testbench



---
 rtl/rr_port_arbiter_pkg.sv | 24 ++
 rtl/rr_port_pick.sv | 40 ++++
 rtl/rr_port_arbiter.sv | 94 +++++++++
 tb/tb_rr_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_port_arbiter_pkg.sv
// Shared definitions for the round-robin port arbiter: FSM encodings and
// the source-index width rule.
package rr_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-bit index is kept even for degenerate widths.
  function automatic int sw_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_port_pick.sv
// Combinational round-robin pick: rotate the eligible set so ptr sits at
// bit 0, take the lowest set bit, then rotate the result back.
module rr_port_pick
  import rr_port_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sw_of(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [2*N-1:0] rot_wide;
  logic [N-1:0]   rot;
  logic [N-1:0]   oh_rot;
  logic [2*N-1:0] unrot_wide;
  logic [SW-1:0]  sel;
  logic [SW:0]    sum;

  always_comb begin
    rot_wide   = {elig, elig} >> ptr;
    rot        = rot_wide[N-1:0];
    sel        = '0;
    oh_rot     = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sel = SW'(j);
    end
    any        = |rot;
    if (any) oh_rot[sel] = 1'b1;
    unrot_wide = {oh_rot, oh_rot} << ptr;
    onehot     = unrot_wide[2*N-1:N];
    sum        = {1'b0, sel} + {1'b0, ptr};
    if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
    idx        = sum[SW-1:0];
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output port among
// N requesters; the current holder is masked for the handshake cycle only.
//
// state   | meaning
// ST_IDLE | output register empty, out_ready ignored
// ST_BUSY | word held until out_ready; may reload back-to-back
module rr_port_arbiter
  import rr_port_arbiter_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  W  = 8,
  localparam int SW = sw_of(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;

  logic [N-1:0]  holder_mask;
  logic [N-1:0]  elig;
  logic          capture;
  logic          pick_any;
  logic [SW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  rr_port_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_BUSY;
      ST_BUSY: if (out_ready && !pick_any) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    holder_mask = {{(N-1){1'b0}}, 1'b1} << out_src_q;
    out_valid   = (state_q == ST_BUSY);
    elig        = '0;
    if (state_q == ST_IDLE) elig = req;
    else if (out_ready)     elig = req & ~holder_mask;
    // elig is already empty whenever a capture is not allowed
    capture = pick_any;
    ptr_d   = (pick_idx == SW'(N - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else if (capture) begin
      ptr_q      <= ptr_d;
      gnt_q      <= pick_onehot;
      out_data_q <= data[int'(pick_idx)*W +: W];
      out_src_q  <= pick_idx;
    end else begin
      gnt_q      <= '0;
    end
  end

  assign gnt      = gnt_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Scoreboard bench for rr_port_arbiter: stimulus queues expected words, a
// negedge monitor pops them on each grant and checks holds under backpressure.
module tb_rr_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;

  int total = 0;
  int bad   = 0;
  logic [SW+W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rr_port_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  task automatic expect_word(input logic [SW-1:0] src, input logic [W-1:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic check_idle(input string name);
    check(name, {out_valid, gnt}, '0);
  endtask

  // monitor
  logic          p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
  logic [SW-1:0] p_src = '0;
  logic [W-1:0]  p_data = '0;

  initial begin
    logic [N-1:0]    oh;
    logic [SW+W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_valid && !p_ready && !p_rst) begin
          check("hold_valid", out_valid, 1);
          check("hold_word", {out_src, out_data}, {p_src, p_data});
          check("hold_no_gnt", gnt, 0);
        end
        if (gnt != '0) begin
          oh = '0;
          oh[out_src] = 1'b1;
          check("gnt_matches_src", gnt, oh);
          check("gnt_with_valid", out_valid, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_gnt: got gnt=%0h src=%0d data=%0h required no grant",
                     gnt, out_src, out_data);
          end else begin
            e = exp_q.pop_front();
            check("word", {out_src, out_data}, e);
          end
        end
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_rst   = rst;
      p_src   = out_src;
      p_data  = out_data;
    end
  end

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;
    data      = {8'h44, 8'h33, 8'h22, 8'h11};

    // reset with all requesting
    repeat (2) begin
      cyc();
      check("rst_gnt", gnt, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_src", out_src, 0);
    end
    rst = 1'b0;
    expect_word(2'd0, 8'h11);
    cyc();
    check("first_valid", out_valid, 1);
    req = 4'b0000;
    out_ready = 1'b1;
    cyc();
    check_idle("idle_after_first");

    // single request, ptr ends at 3
    out_ready = 1'b0;
    set_word(2, 8'hA5);
    req = 4'b0100;
    out_ready = 1'b1;
    expect_word(2'd2, 8'hA5);
    cyc();
    check("single_gnt", gnt, 4'b0100);
    check("single_word", {out_src, out_data}, {2'd2, 8'hA5});
    req = 4'b0000;
    cyc();
    check_idle("idle_after_single");

    // wrap and holder masking: 3, then 0, then 3 again
    set_word(0, 8'h50);
    set_word(3, 8'h53);
    req = 4'b1001;
    expect_word(2'd3, 8'h53);
    expect_word(2'd0, 8'h50);
    expect_word(2'd3, 8'h53);
    repeat (3) cyc();
    req = 4'b0000;
    cyc();
    check_idle("idle_after_wrap");

    // full contention from ptr 0
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    expect_word(2'd0, 8'h11);
    expect_word(2'd1, 8'h22);
    expect_word(2'd2, 8'h33);
    expect_word(2'd3, 8'h44);
    expect_word(2'd0, 8'h11);
    repeat (5) begin
      cyc();
      check("no_bubble", {out_valid, (gnt != '0)}, 2'b11);
    end

    // backpressure: holder 0 frozen although its data changes
    out_ready = 1'b0;
    set_word(0, 8'hEE);
    repeat (5) cyc();
    check("bp_frozen", {out_src, out_data}, {2'd0, 8'h11});
    out_ready = 1'b1;
    expect_word(2'd1, 8'h22);
    cyc();
    req = 4'b0000;
    cyc();
    check_idle("idle_after_bp");

    // ready while idle changes nothing
    repeat (3) begin
      cyc();
      check_idle("ready_in_idle");
    end

    // reset while busy: held word dropped, ptr back to 0
    out_ready = 1'b0;
    req = 4'b0010;
    expect_word(2'd1, 8'h22);
    cyc();
    req = 4'b0000;
    cyc();
    check("busy_before_rst", out_valid, 1);
    rst = 1'b1;
    cyc();
    check("midrst_valid", out_valid, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_word", {out_src, out_data}, 0);
    rst = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    expect_word(2'd0, 8'hEE);
    cyc();
    check("post_rst_src", out_src, 0);
    req = 4'b0000;
    cyc();
    check_idle("idle_final");
    cyc();
    cyc();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
